// File: rtl/lock_pkg.sv
// Shared encodings and helpers for the keypad combination-lock controller.
// State values are fixed because the VGA display stage decodes state_o directly.
package lock_pkg;

    localparam int STATE_W = 3;
    localparam int DIGIT_W = 2;
    localparam int NUM_BTN = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_CHECK    = 3'd2,
        S_UNLOCKED = 3'd3,
        S_LOCKOUT  = 3'd4
    } lock_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Scanning from the top down leaves the lowest pressed index as the result.
    function automatic logic [DIGIT_W-1:0] lowest_digit(input logic [NUM_BTN-1:0] press);
        logic [DIGIT_W-1:0] result;
        result = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press[i]) result = DIGIT_W'(i);
        end
        return result;
    endfunction

endpackage

// File: rtl/combo_lock_ctrl_if.sv
// Bundle between the lock controller and its neighbours: slow clock and buttons in,
// registered status out to the display stage.
interface combo_lock_ctrl_if;
    import lock_pkg::*;

    logic               slow_clk;
    logic [NUM_BTN-1:0] btn;
    logic               unlocked;
    logic               locked_out;
    logic [2:0]         digit_cnt;
    logic [1:0]         fail_cnt;
    logic [STATE_W-1:0] state_o;
    logic               tick_o;

    modport master (
        output slow_clk, btn,
        input  unlocked, locked_out, digit_cnt, fail_cnt, state_o, tick_o
    );

    modport slave (
        input  slow_clk, btn,
        output unlocked, locked_out, digit_cnt, fail_cnt, state_o, tick_o
    );

endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser plus tick-sampled saturating counter that emits a
// single press pulse per hold; one low sample re-arms it.
module btn_debounce #(
    parameter int DEB_TICKS = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_btn_raw,
    output logic o_press
);

    localparam int                CNT_W    = $clog2(DEB_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEB_TICKS);
    localparam logic [CNT_W-1:0]  CNT_ARM  = CNT_W'(DEB_TICKS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (i_tick) begin
                if (r_sync2) begin
                    if (r_cnt != CNT_FULL) r_cnt <= r_cnt + CNT_W'(1);
                    r_press <= (r_cnt == CNT_ARM);
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/combo_lock_ctrl.sv
// Keypad combination lock: slow-clock tick extraction, four debouncers, entry capture,
// code compare and unlock/lockout/entry timing around a single down-counting timer.
module combo_lock_ctrl
    import lock_pkg::*;
#(
    parameter int                    CODE_LEN      = 4,
    parameter logic [2*CODE_LEN-1:0] CODE          = 8'b11100100,
    parameter int                    DEB_TICKS     = 2,
    parameter int                    MAX_FAILS     = 3,
    parameter int                    UNLOCK_TICKS  = 100,
    parameter int                    LOCKOUT_TICKS = 200,
    parameter int                    ENTRY_TICKS   = 100
) (
    input logic              clk_in,
    input logic              rst_n,
    combo_lock_ctrl_if.slave bus
);

    localparam int                   ENTRY_W      = DIGIT_W * CODE_LEN;
    localparam int                   TIMER_W      = $clog2(max3(UNLOCK_TICKS, LOCKOUT_TICKS, ENTRY_TICKS) + 1);
    localparam logic [TIMER_W-1:0]   UNLOCK_LOAD  = TIMER_W'(UNLOCK_TICKS);
    localparam logic [TIMER_W-1:0]   LOCKOUT_LOAD = TIMER_W'(LOCKOUT_TICKS);
    localparam logic [TIMER_W-1:0]   ENTRY_LOAD   = TIMER_W'(ENTRY_TICKS);
    localparam logic [2:0]           LAST_SLOT    = 3'(CODE_LEN - 1);
    localparam logic [1:0]           FAIL_LIMIT   = 2'(MAX_FAILS);

    logic               r_slow_sync1;
    logic               r_slow_sync2;
    logic               r_slow_prev;
    logic               r_tick;

    lock_state_e        r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [ENTRY_W-1:0] r_entry;
    logic [2:0]         r_digit_cnt;
    logic [1:0]         r_fail_cnt;
    logic               r_unlocked;
    logic               r_locked_out;

    logic [NUM_BTN-1:0] w_press;
    logic               w_any_press;
    logic [DIGIT_W-1:0] w_digit;
    logic [ENTRY_W-1:0] w_entry_ins;
    logic               w_code_match;
    logic [1:0]         w_fail_next;
    logic               w_timer_last;

    // slow_clk is asynchronous data: synchronise, then register a one-cycle rising-edge tick.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_slow_sync1 <= 1'b0;
            r_slow_sync2 <= 1'b0;
            r_slow_prev  <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_slow_sync1 <= bus.slow_clk;
            r_slow_sync2 <= r_slow_sync1;
            r_slow_prev  <= r_slow_sync2;
            r_tick       <= r_slow_sync2 & ~r_slow_prev;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        btn_debounce #(
            .DEB_TICKS (DEB_TICKS)
        ) u_deb (
            .clk_in    (clk_in),
            .rst_n     (rst_n),
            .i_tick    (r_tick),
            .i_btn_raw (bus.btn[g]),
            .o_press   (w_press[g])
        );
    end

    assign w_any_press  = |w_press;
    assign w_digit      = lowest_digit(w_press);
    assign w_code_match = (r_entry == CODE);
    assign w_fail_next  = r_fail_cnt + 2'd1;
    assign w_timer_last = (r_timer <= TIMER_W'(1));

    always_comb begin
        w_entry_ins = r_entry;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (r_digit_cnt == 3'(i)) w_entry_ins[i*DIGIT_W +: DIGIT_W] = w_digit;
        end
    end

    // Timer reloads on every accepted digit so it measures idle time within an entry.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_entry      <= '0;
            r_digit_cnt  <= '0;
            r_fail_cnt   <= '0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_press) begin
                        r_entry     <= ENTRY_W'(w_digit);
                        r_digit_cnt <= 3'd1;
                        r_timer     <= ENTRY_LOAD;
                        r_state     <= (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (w_any_press) begin
                        r_entry     <= w_entry_ins;
                        r_digit_cnt <= r_digit_cnt + 3'd1;
                        r_timer     <= ENTRY_LOAD;
                        if (r_digit_cnt == LAST_SLOT) r_state <= S_CHECK;
                    end else if (r_tick) begin
                        if (w_timer_last) begin
                            r_state     <= S_IDLE;
                            r_timer     <= '0;
                            r_digit_cnt <= '0;
                            r_entry     <= '0;
                        end else begin
                            r_timer <= r_timer - TIMER_W'(1);
                        end
                    end
                end
                S_CHECK: begin
                    r_digit_cnt <= '0;
                    r_entry     <= '0;
                    if (w_code_match) begin
                        r_state    <= S_UNLOCKED;
                        r_unlocked <= 1'b1;
                        r_fail_cnt <= '0;
                        r_timer    <= UNLOCK_LOAD;
                    end else if (w_fail_next == FAIL_LIMIT) begin
                        r_state      <= S_LOCKOUT;
                        r_locked_out <= 1'b1;
                        r_fail_cnt   <= w_fail_next;
                        r_timer      <= LOCKOUT_LOAD;
                    end else begin
                        r_state    <= S_IDLE;
                        r_fail_cnt <= w_fail_next;
                        r_timer    <= '0;
                    end
                end
                S_UNLOCKED: begin
                    if (r_tick) begin
                        if (w_timer_last) begin
                            r_state    <= S_IDLE;
                            r_unlocked <= 1'b0;
                            r_timer    <= '0;
                        end else begin
                            r_timer <= r_timer - TIMER_W'(1);
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (r_tick) begin
                        if (w_timer_last) begin
                            r_state      <= S_IDLE;
                            r_locked_out <= 1'b0;
                            r_fail_cnt   <= '0;
                            r_timer      <= '0;
                        end else begin
                            r_timer <= r_timer - TIMER_W'(1);
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_timer      <= '0;
                    r_entry      <= '0;
                    r_digit_cnt  <= '0;
                    r_unlocked   <= 1'b0;
                    r_locked_out <= 1'b0;
                end
            endcase
        end
    end

    assign bus.unlocked   = r_unlocked;
    assign bus.locked_out = r_locked_out;
    assign bus.digit_cnt  = r_digit_cnt;
    assign bus.fail_cnt   = r_fail_cnt;
    assign bus.state_o    = r_state;
    assign bus.tick_o     = r_tick;

endmodule
